alarm_ring_controller: RTL

ALARM_RING_CONTROLLER -- requirements
Module: alarm_ring_controller

---
 rtl/alarm_ctrl_pkg.sv | 15 +
 rtl/sec_down_counter.sv | 25 ++
 rtl/alarm_ring_controller.sv | 138 +++++++++++++
 3 files changed

// File: rtl/alarm_ctrl_pkg.sv
// State encoding and default timing constants shared by the alarm ring controller files.
package alarm_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRinging = 2'd1,
        StSnooze  = 2'd2,
        StDone    = 2'd3
    } alarm_state_e;

    localparam int unsigned DefRingTimeout   = 60;
    localparam int unsigned DefSnoozeSeconds = 300;
    localparam int unsigned DefMaxSnoozes    = 3;

endpackage

// File: rtl/sec_down_counter.sv
// 9-bit seconds down-counter with synchronous load; holds at zero instead of wrapping.
module sec_down_counter (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_load,
    input  logic [8:0] i_load_val,
    input  logic       i_dec,
    output logic       o_zero
);

    logic [8:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 9'd1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/alarm_ring_controller.sv
// Alarm ring sequencer: IDLE -> RINGING -> (SNOOZE) -> DONE on a 1 Hz clock.
// Snooze support is built only when ALARM_SNOOZE_EN is defined.
module alarm_ring_controller
    import alarm_ctrl_pkg::*;
#(
    parameter int unsigned RING_TIMEOUT   = DefRingTimeout,
    parameter int unsigned SNOOZE_SECONDS = DefSnoozeSeconds,
    parameter int unsigned MAX_SNOOZES    = DefMaxSnoozes
) (
    input  logic       Clk_1sec,
    input  logic       reset_in,
    input  logic       alarm_ring_in,
    input  logic       alarm_enable_in,
    input  logic       snooze_in,
    input  logic       stop_in,
    output logic       buzzer_out,
    output logic       ringing_out,
    output logic       snoozing_out,
    output logic [2:0] snooze_count_out,
    output logic [5:0] ring_seconds_out
);

    localparam logic [5:0] RingLast = 6'(RING_TIMEOUT - 1);

    alarm_state_e r_state;
    alarm_state_e w_state_nxt;
    logic         r_ring_prev;
    logic [5:0]   r_ring_sec;
    logic [5:0]   w_ring_sec_nxt;
    logic         w_ring_rise;

    assign w_ring_rise = alarm_ring_in & ~r_ring_prev;

`ifdef ALARM_SNOOZE_EN
    localparam logic [8:0] SnoozeLoad = 9'(SNOOZE_SECONDS - 1);
    localparam logic [2:0] MaxSnoozes = 3'(MAX_SNOOZES);

    logic [2:0] r_snz_cnt;
    logic [2:0] w_snz_cnt_nxt;
    logic       w_tmr_load;
    logic       w_tmr_dec;
    logic       w_tmr_zero;

    sec_down_counter u_snooze_timer (
        .i_clk      (Clk_1sec),
        .i_rst      (reset_in),
        .i_load     (w_tmr_load),
        .i_load_val (SnoozeLoad),
        .i_dec      (w_tmr_dec),
        .o_zero     (w_tmr_zero)
    );
`else
    logic w_unused_snooze;
    assign w_unused_snooze = snooze_in ^ SNOOZE_SECONDS[0] ^ MAX_SNOOZES[0];
`endif

    always_ff @(posedge Clk_1sec) begin
        if (reset_in) begin
            r_state     <= StIdle;
            r_ring_prev <= 1'b0;
            r_ring_sec  <= '0;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt   <= '0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_ring_prev <= alarm_ring_in;
            r_ring_sec  <= w_ring_sec_nxt;
`ifdef ALARM_SNOOZE_EN
            r_snz_cnt   <= w_snz_cnt_nxt;
`endif
        end
    end

    // Ring counter defaults to 0 so every exit from RINGING clears it.
    always_comb begin
        w_state_nxt    = r_state;
        w_ring_sec_nxt = '0;
`ifdef ALARM_SNOOZE_EN
        w_snz_cnt_nxt  = r_snz_cnt;
        w_tmr_load     = 1'b0;
        w_tmr_dec      = 1'b0;
`endif
        unique case (r_state)
            StIdle: begin
                if (w_ring_rise && alarm_enable_in) begin
                    w_state_nxt = StRinging;
                end
            end
            StRinging: begin
                if (stop_in || !alarm_enable_in) begin
                    w_state_nxt = StDone;
`ifdef ALARM_SNOOZE_EN
                end else if (snooze_in && (r_snz_cnt < MaxSnoozes)) begin
                    w_state_nxt   = StSnooze;
                    w_snz_cnt_nxt = r_snz_cnt + 3'd1;
                    w_tmr_load    = 1'b1;
`endif
                end else if (r_ring_sec == RingLast) begin
                    w_state_nxt = StDone;
                end else begin
                    w_ring_sec_nxt = r_ring_sec + 6'd1;
                end
            end
`ifdef ALARM_SNOOZE_EN
            StSnooze: begin
                w_tmr_dec = 1'b1;
                if (stop_in || !alarm_enable_in) begin
                    w_state_nxt = StDone;
                end else if (w_tmr_zero) begin
                    w_state_nxt = StRinging;
                end
            end
`endif
            StDone: begin
                if (!alarm_ring_in) begin
                    w_state_nxt = StIdle;
`ifdef ALARM_SNOOZE_EN
                    w_snz_cnt_nxt = '0;
`endif
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    assign ringing_out      = (r_state == StRinging);
    assign buzzer_out       = ringing_out & ~r_ring_sec[0];
    assign ring_seconds_out = r_ring_sec;
`ifdef ALARM_SNOOZE_EN
    assign snoozing_out     = (r_state == StSnooze);
    assign snooze_count_out = r_snz_cnt;
`else
    assign snoozing_out     = 1'b0;
    assign snooze_count_out = '0;
`endif

endmodule
